// File: rtl/mem_stage_port.sv
// MEM-stage initiator: splits a pipeline load/store into big-endian byte
// transactions on a req/ack data memory and stalls the pipeline until done.
module mem_stage_port #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       EXE_MEM_Result,
    input  logic [31:0]       EXE_MEM_Rt,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        MemSize,
    input  logic              MemSigned,
    output logic [31:0]       MEM_Result,
    output logic              stall,
    output logic              misaligned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Index of the final byte of an item: 0, 1 or 3.
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        logic [1:0] r;
        case (size)
            2'b00:   r = 2'd0;
            2'b01:   r = 2'd1;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = lsb[0];
            default: r = (lsb != 2'b00);
        endcase
        return r;
    endfunction

    // Big-endian: byte idx 0 is the most significant byte of the item.
    function automatic logic [7:0] write_byte(input logic [31:0] rt, input logic [1:0] size,
                                              input logic [1:0] idx);
        logic [1:0] sel;
        logic [7:0] r;
        sel = last_idx(size) - idx;
        case (sel)
            2'd0:    r = rt[7:0];
            2'd1:    r = rt[15:8];
            2'd2:    r = rt[23:16];
            default: r = rt[31:24];
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] acc, input logic [1:0] size,
                                           input logic sgn);
        logic [31:0] r;
        case (size)
            2'b00:   r = sgn ? {{24{acc[7]}}, acc[7:0]} : {24'd0, acc[7:0]};
            2'b01:   r = sgn ? {{16{acc[15]}}, acc[15:0]} : {16'd0, acc[15:0]};
            default: r = acc;
        endcase
        return r;
    endfunction

    state_t              state_r, state_n;
    logic [ADDR_W-1:0]   base_r, base_n;
    logic [31:0]         rt_r, rt_n;
    logic [1:0]          size_r, size_n;
    logic                sgn_r, sgn_n;
    logic                op_we_r, op_we_n;
    logic [1:0]          idx_r, idx_n;
    logic [31:0]         acc_r, acc_n;
    logic                req_r, req_n;
    logic                we_r, we_n;
    logic [ADDR_W-1:0]   addr_r, addr_n;
    logic [7:0]          wdata_r, wdata_n;
    logic                mis_r, mis_n;
    logic [31:0]         result_r, result_n;

    logic                req_s;
    logic                mis_s;
    logic [1:0]          idx_inc_s;
    logic                unused_s;

    assign req_s     = MemRead | MemWrite;
    assign mis_s     = is_misaligned(MemSize, EXE_MEM_Result[1:0]);
    assign idx_inc_s = idx_r + 2'd1;
    assign unused_s  = ^EXE_MEM_Result[31:ADDR_W];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and next-register values; everything holds unless updated.
    always_comb begin
        state_n  = state_r;
        base_n   = base_r;
        rt_n     = rt_r;
        size_n   = size_r;
        sgn_n    = sgn_r;
        op_we_n  = op_we_r;
        idx_n    = idx_r;
        acc_n    = acc_r;
        req_n    = req_r;
        we_n     = we_r;
        addr_n   = addr_r;
        wdata_n  = wdata_r;
        mis_n    = 1'b0;
        result_n = result_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    base_n  = EXE_MEM_Result[ADDR_W-1:0];
                    rt_n    = EXE_MEM_Rt;
                    size_n  = MemSize;
                    sgn_n   = MemSigned;
                    op_we_n = MemWrite;
                    idx_n   = 2'd0;
                    acc_n   = 32'd0;
                    if (mis_s) begin
                        state_n = DONE;
                        mis_n   = 1'b1;
                    end else begin
                        state_n = ACCESS;
                        req_n   = 1'b1;
                        we_n    = MemWrite;
                        addr_n  = EXE_MEM_Result[ADDR_W-1:0];
                        wdata_n = write_byte(EXE_MEM_Rt, MemSize, 2'd0);
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    acc_n = {acc_r[23:0], mem_rdata};
                    if (idx_r == last_idx(size_r)) begin
                        state_n = DONE;
                        req_n   = 1'b0;
                        we_n    = 1'b0;
                    end else begin
                        idx_n   = idx_inc_s;
                        addr_n  = base_r + ADDR_W'(idx_inc_s);
                        wdata_n = write_byte(rt_r, size_r, idx_inc_s);
                    end
                end else begin
                    state_n = ACCESS;
                end
            end
            DONE: begin
                state_n = IDLE;
                if (!op_we_r && !mis_r) begin
                    result_n = extend(acc_r, size_r, sgn_r);
                end else begin
                    result_n = result_r;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operation context, accumulator and registered memory-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_r   <= '0;
            rt_r     <= 32'd0;
            size_r   <= 2'd0;
            sgn_r    <= 1'b0;
            op_we_r  <= 1'b0;
            idx_r    <= 2'd0;
            acc_r    <= 32'd0;
            req_r    <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= 8'd0;
            mis_r    <= 1'b0;
            result_r <= 32'd0;
        end else begin
            base_r   <= base_n;
            rt_r     <= rt_n;
            size_r   <= size_n;
            sgn_r    <= sgn_n;
            op_we_r  <= op_we_n;
            idx_r    <= idx_n;
            acc_r    <= acc_n;
            req_r    <= req_n;
            we_r     <= we_n;
            addr_r   <= addr_n;
            wdata_r  <= wdata_n;
            mis_r    <= mis_n;
            result_r <= result_n;
        end
    end

    // stall follows the request combinationally so the accepting cycle freezes too.
    assign stall      = !rst && (((state_r == IDLE) && req_s) || (state_r == ACCESS));
    assign MEM_Result = result_r;
    assign misaligned = mis_r;
    assign mem_req    = req_r;
    assign mem_we     = we_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r;

endmodule

// File: tb/tb_mem_stage_port.sv
// Directed bench for mem_stage_port with a byte-wide memory model and
// configurable ack latency.
module tb_mem_stage_port;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   exe_result, exe_rt;
    logic          mem_read, mem_write, mem_signed;
    logic [1:0]    mem_size;
    logic [31:0]   mem_result;
    logic          stall, misaligned, mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;

    logic [7:0]    mem [0:1023];
    logic          init_mem;
    int            delay = 0;
    int            wcnt = 0;

    int            tx_total = 0;
    logic [AW-1:0] tx_addr [0:63];
    logic          tx_we [0:63];
    logic [7:0]    tx_wd [0:63];

    int            req_cnt = 0, mis_cnt = 0, stab_n = 0, stab_err = 0;
    logic          wait_prev = 1'b0;
    logic [AW-1:0] prev_addr;
    logic          prev_we;
    logic [7:0]    prev_wd;

    int            checks = 0, failures = 0;
    int            stall_cnt;
    logic          done_ok;
    int            t0, r0, m0, s0, e0;

    mem_stage_port #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .EXE_MEM_Result(exe_result), .EXE_MEM_Rt(exe_rt),
        .MemRead(mem_read), .MemWrite(mem_write), .MemSize(mem_size), .MemSigned(mem_signed),
        .MEM_Result(mem_result), .stall(stall), .misaligned(misaligned),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && (wcnt == delay);

    always @(posedge clk) begin
        if (init_mem) begin
            for (int k = 0; k < 1024; k++) mem[k] <= (((k + 1) % 4) == 0) ? 8'(k + 1) : 8'h00;
            mem[15] <= 8'h90;
        end else if (mem_req && mem_ack && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always @(posedge clk) begin
        wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
        if (mem_req && mem_ack) begin
            if (tx_total < 64) begin
                tx_addr[tx_total] <= mem_addr;
                tx_we[tx_total]   <= mem_we;
                tx_wd[tx_total]   <= mem_wdata;
            end
            tx_total <= tx_total + 1;
        end
        if (wait_prev) begin
            stab_n <= stab_n + 1;
            if (mem_addr != prev_addr || mem_we != prev_we || mem_wdata != prev_wd)
                stab_err <= stab_err + 1;
        end
        wait_prev <= mem_req && !mem_ack;
        prev_addr <= mem_addr;
        prev_we   <= mem_we;
        prev_wd   <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_req) req_cnt <= req_cnt + 1;
        if (misaligned) mis_cnt <= mis_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, count stall cycles until DONE, drop the request, settle one cycle.
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] rt);
        exe_result = a; exe_rt = rt; mem_size = sz; mem_signed = sg;
        mem_read = rd; mem_write = wr;
        #1;
        stall_cnt = 0;
        done_ok = 1'b0;
        for (int c = 0; c < 80 && !done_ok; c++) begin
            if (stall) begin
                stall_cnt++;
                @(negedge clk);
            end else begin
                done_ok = 1'b1;
            end
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        check("op_done", 32'(done_ok), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; init_mem = 1'b1;
        exe_result = 32'd0; exe_rt = 32'd0; mem_size = 2'b00; mem_signed = 1'b0;
        mem_read = 1'b1; mem_write = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_result", mem_result, 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_mis", 32'(misaligned), 32'd0);
        init_mem = 1'b0; mem_read = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("idle_stall", 32'(stall), 32'd0);

        t0 = tx_total;
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'd0);
        check("lw4_stall", stall_cnt, 32'd5);
        check("lw4_result", mem_result, 32'h0000_0008);
        check("lw4_ntx", tx_total - t0, 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("lw4_addr", 32'(tx_addr[t0 + k]), 32'(4 + k));
            check("lw4_we", 32'(tx_we[t0 + k]), 32'd0);
        end

        run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_000F, 32'd0);
        check("lb_stall", stall_cnt, 32'd2);
        check("lb_result", mem_result, 32'hFFFF_FF90);
        run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_000F, 32'd0);
        check("lbu_stall", stall_cnt, 32'd2);
        check("lbu_result", mem_result, 32'h0000_0090);

        t0 = tx_total;
        run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'hABCD_1234);
        check("sh_stall", stall_cnt, 32'd3);
        check("sh_result_hold", mem_result, 32'h0000_0090);
        check("sh_ntx", tx_total - t0, 32'd2);
        check("sh_tx0_addr", 32'(tx_addr[t0]), 32'h12);
        check("sh_tx0_data", 32'(tx_wd[t0]), 32'h12);
        check("sh_tx0_we", 32'(tx_we[t0]), 32'd1);
        check("sh_tx1_addr", 32'(tx_addr[t0 + 1]), 32'h13);
        check("sh_tx1_data", 32'(tx_wd[t0 + 1]), 32'h34);
        check("sh_mem12", 32'(mem[18]), 32'h12);
        check("sh_mem13", 32'(mem[19]), 32'h34);
        run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'd0);
        check("lhu_stall", stall_cnt, 32'd3);
        check("lhu_result", mem_result, 32'h0000_1234);

        delay = 2;
        s0 = stab_n; e0 = stab_err;
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'd0);
        check("lw8_wait_stall", stall_cnt, 32'd13);
        check("lw8_wait_result", mem_result, 32'h0000_000C);
        check("lw8_wait_samples", stab_n - s0, 32'd8);
        check("lw8_wait_stable", stab_err - e0, 32'd0);
        delay = 0;

        r0 = req_cnt; m0 = mis_cnt;
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'd0);
        check("lw6_stall", stall_cnt, 32'd1);
        check("lw6_mis", mis_cnt - m0, 32'd1);
        check("lw6_noreq", req_cnt - r0, 32'd0);
        check("lw6_result", mem_result, 32'h0000_000C);
        r0 = req_cnt; m0 = mis_cnt;
        run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0003, 32'd0);
        check("lh3_stall", stall_cnt, 32'd1);
        check("lh3_mis", mis_cnt - m0, 32'd1);
        check("lh3_noreq", req_cnt - r0, 32'd0);
        check("lh3_result", mem_result, 32'h0000_000C);

        t0 = tx_total;
        exe_result = 32'h0000_0020; exe_rt = 32'hDEAD_BEEF; mem_size = 2'b10;
        mem_signed = 1'b0; mem_write = 1'b1;
        for (int c = 0; c < 20 && (tx_total - t0) < 2; c++) @(negedge clk);
        check("sw_two_acked", tx_total - t0, 32'd2);
        rst = 1'b1; mem_write = 1'b0;
        #1;
        check("abort_req", 32'(mem_req), 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_we", 32'(mem_we), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_wdata", 32'(mem_wdata), 32'd0);
        check("abort_mis", 32'(misaligned), 32'd0);
        check("abort_result", mem_result, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ntx", tx_total - t0, 32'd2);
        check("abort_mem20", 32'(mem[32]), 32'hDE);
        check("abort_mem21", 32'(mem[33]), 32'hAD);
        check("abort_mem22", 32'(mem[34]), 32'h00);
        check("abort_mem23", 32'(mem[35]), 32'h24);
        check("abort_idle_result", mem_result, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
